uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4: number of requesters sharing one UART transmitter.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8: frame payload width.
REQ-003 The block SHALL have parameter BUSY_TIMEOUT, default 16: cycles allowed for busy to rise after transmit is asserted.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port req_valid, input, NUM_REQ bits: bit i high means requester i has a byte pending.
REQ-007 The block SHALL have port req_data, input, NUM_REQ*DATA_WIDTH bits: requester i's byte at [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 The block SHALL have port req_ready, output, NUM_REQ bits: one-hot, one-cycle accept pulse.
REQ-009 The block SHALL have port TX_Data, output, DATA_WIDTH bits: byte driven to the UART transmitter.
REQ-010 The block SHALL have port transmit, output, 1 bit: start request to the UART transmitter.
REQ-011 The block SHALL have port busy, input, 1 bit: UART transmitter busy flag.
REQ-012 The block SHALL have port grant_id, output, clog2(NUM_REQ) bits: index of the current or last granted requester.
REQ-013 The block SHALL have port active, output, 1 bit: high whenever the state is not IDLE.
REQ-014 The block SHALL have port timeout_err, output, 1 bit: one-cycle pulse when busy fails to rise.

Function
REQ-015 The FSM SHALL have the states IDLE, WAIT_BUSY and WAIT_DONE; all outputs SHALL be registered.
REQ-016 In IDLE, at an edge where any req_valid is 1 and busy is 0, the block SHALL choose winner w round-robin, searching from (last_grant+1) mod NUM_REQ upward with wrap.
REQ-017 At that grant edge, the block SHALL set TX_Data to w's byte, grant_id and last_grant to w, req_ready to one-hot w for exactly one cycle, and transmit to 1, then enter WAIT_BUSY.
REQ-018 In IDLE with busy=1, no grant SHALL occur, whatever req_valid is.
REQ-019 Requesters SHALL hold req_valid and data until req_ready; req_valid changes after the accept SHALL NOT affect the frame.
REQ-020 TX_Data SHALL remain stable from the grant until the next grant.
REQ-021 In WAIT_BUSY, transmit SHALL stay 1 until busy is sampled 1; at that edge transmit goes to 0 and the state goes to WAIT_DONE.
REQ-022 In WAIT_BUSY, a cycle counter SHALL count from 0; if it reaches BUSY_TIMEOUT-1 with busy still 0, then at that edge transmit goes to 0, timeout_err pulses for 1 cycle, and the state returns to IDLE.
REQ-023 A timed-out requester SHALL NOT be retried, and last_grant SHALL keep the value w.
REQ-024 In WAIT_DONE, at the edge where busy is sampled 0, the state SHALL return to IDLE; the next grant is possible no earlier than the following edge.
REQ-025 A single active requester SHALL receive consecutive grants; with all requesters valid, the grant order SHALL be 0,1,2,3,0,...
REQ-026 Changes on req_valid in WAIT_BUSY or WAIT_DONE SHALL be ignored until IDLE.

Reset
REQ-027 On reset=1 at an edge, the block SHALL enter IDLE and clear transmit, req_ready, timeout_err, active, TX_Data, grant_id and the counter to 0; last_grant SHALL be set to NUM_REQ-1 so requester 0 has first priority.
REQ-028 Reset mid-frame SHALL drop transmit to 0 at that edge with no req_ready or timeout_err pulse; reset has priority over all transitions.

Verification
REQ-029 Reset, then req_valid=4'b0001 with byte 0xA5, and a UART model raising busy 2 cycles after transmit and holding it 20 cycles -> req_ready=0001 for 1 cycle, TX_Data=0xA5, grant_id=0, transmit falls the cycle after busy rises.
REQ-030 req_valid=4'b1111 held, bytes 0x11/0x22/0x33/0x44 -> frames in order 0x11, 0x22, 0x33, 0x44, 0x11; each req_ready is one-hot and pulses once per frame.
REQ-031 busy tied 0 after a grant -> transmit is high for exactly 16 cycles, timeout_err pulses once, the block returns to IDLE, and the next grant goes to (w+1).
REQ-032 busy=1 externally while in IDLE with req_valid=4'b0010 -> no req_ready and transmit stays 0 until busy=0, then grant to requester 1.
REQ-033 reset pulsed in WAIT_DONE -> next cycle transmit=0, active=0, grant_id=0; with req_valid=4'b1001 after reset, requester 0 is granted first.
REQ-034 Randomized 100-frame run with a UART loopback -> every received byte equals the granted TX_Data, and no requester starves (at most NUM_REQ-1 grants to others between its request and its grant).

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one UART transmitter among NUM_REQ
// byte requesters, with a watchdog on the transmitter's busy handshake.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int BUSY_TIMEOUT = 16,
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         TX_Data,
    output logic                          transmit,
    input  logic                          busy,
    output logic [IDW-1:0]                grant_id,
    output logic                          active,
    output logic                          timeout_err
);

    localparam int CW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IDW-1:0]          last_q, last_d;
    logic [IDW-1:0]          gid_q, gid_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [NUM_REQ-1:0]      rdy_q, rdy_d;
    logic                    tx_q, tx_d;
    logic                    act_q, act_d;
    logic                    to_q, to_d;

    logic                    found;
    logic [IDW-1:0]          win;
    logic [DATA_WIDTH-1:0]   win_data;

    // Search starts just after the last winner so every requester waits
    // at most NUM_REQ-1 grants.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int idx;
            idx = int'(last_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req_valid[IDW'(idx)]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IDW'(i) == win) win_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        gid_d   = gid_q;
        data_d  = data_q;
        tx_d    = tx_q;
        rdy_d   = '0;
        to_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (found && !busy) begin
                    data_d  = win_data;
                    gid_d   = win;
                    last_d  = win;
                    rdy_d   = NUM_REQ'(1) << win;
                    tx_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (busy) begin
                    tx_d    = 1'b0;
                    state_d = WAIT_DONE;
                end else if (cnt_q == CW'(BUSY_TIMEOUT - 1)) begin
                    // Abandon the frame; the next search still starts after w.
                    tx_d    = 1'b0;
                    to_d    = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!busy) state_d = IDLE;
            end
            default: begin
                tx_d    = 1'b0;
                state_d = IDLE;
            end
        endcase

        act_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= IDW'(NUM_REQ - 1);
            gid_q   <= '0;
            data_q  <= '0;
            rdy_q   <= '0;
            tx_q    <= 1'b0;
            act_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            gid_q   <= gid_d;
            data_q  <= data_d;
            rdy_q   <= rdy_d;
            tx_q    <= tx_d;
            act_q   <= act_d;
            to_q    <= to_d;
        end
    end

    assign req_ready   = rdy_q;
    assign TX_Data     = data_q;
    assign transmit    = tx_q;
    assign grant_id    = gid_q;
    assign active      = act_q;
    assign timeout_err = to_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and randomized checks of the arbiter against
// a behavioural UART model, round-robin reference and byte scoreboard.
module tb_uart_tx_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req_valid;
    logic [3:0][7:0] dbytes;
    logic [31:0]  req_data;
    logic [3:0]   req_ready;
    logic [7:0]   TX_Data;
    logic         transmit;
    logic         busy;
    logic [1:0]   grant_id;
    logic         active;
    logic         timeout_err;

    logic         force_busy;
    logic         uart_busy;
    logic         uart_en;
    logic         rand_mode;
    int           dly_cfg;
    int           len_cfg;

    int n_asserts = 0;
    int n_fail    = 0;
    int grant_cnt = 0;
    int to_cnt    = 0;
    int tb_last   = 3;
    int exp_q[$];
    logic [7:0] exp_byte_q[$];
    int wait_cnt[4];

    assign req_data = dbytes;
    assign busy     = force_busy | uart_busy;

    uart_tx_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .TX_Data     (TX_Data),
        .transmit    (transmit),
        .busy        (busy),
        .grant_id    (grant_id),
        .active      (active),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int rr(logic [3:0] v, int last);
        int r;
        int idx;
        r = -1;
        for (int k = 1; k <= 4; k++) begin
            idx = (last + k) % 4;
            if (v[idx] && r < 0) r = idx;
        end
        return r;
    endfunction

    // Monitor, UART model and random requesters: sample on the falling
    // edge, drive 1 time unit later.
    int   ph = 0;
    int   ud = 0;
    int   ul = 0;
    logic prev_rdy = 1'b0;

    always @(negedge clk) begin : mon
        int  w;
        int  gw;
        logic started;
        gw      = -1;
        started = 1'b0;
        if (prev_rdy) chk("ready_one_cycle", req_ready, 4'b0000);
        if (req_ready !== 4'b0000) begin
            w = rr(req_valid, tb_last);
            chk("grant_has_valid", w >= 0, 1);
            if (w >= 0) begin
                chk("ready_onehot", req_ready, 4'b0001 << w);
                chk("grant_id", grant_id, w);
                chk("grant_data", TX_Data, dbytes[w]);
                chk("grant_transmit", transmit, 1);
                if (exp_q.size() > 0) chk("grant_order", w, exp_q.pop_front());
                chk("no_starve", wait_cnt[w] <= 3, 1);
                for (int i = 0; i < 4; i++)
                    if (i != w && req_valid[i]) wait_cnt[i]++;
                wait_cnt[w] = 0;
                if (uart_en) exp_byte_q.push_back(dbytes[w]);
                tb_last = w;
                gw      = w;
            end
            grant_cnt++;
        end
        if (timeout_err === 1'b1) to_cnt++;
        prev_rdy = (req_ready !== 4'b0000);

        if (uart_en && ph == 0 && transmit === 1'b1) begin
            chk("loopback_expected", exp_byte_q.size() > 0, 1);
            if (exp_byte_q.size() > 0) chk("loopback_byte", TX_Data, exp_byte_q.pop_front());
            if (rand_mode) begin
                ud = $urandom_range(1, 3);
                ul = $urandom_range(1, 6);
            end else begin
                ud = dly_cfg;
                ul = len_cfg;
            end
            ph      = 1;
            started = 1'b1;
        end

        #1;
        if (!started) begin
            if (ph == 1) begin
                ud--;
                if (ud <= 0) begin
                    uart_busy = 1'b1;
                    ph        = 2;
                end
            end else if (ph == 2) begin
                ul--;
                if (ul <= 0) begin
                    uart_busy = 1'b0;
                    ph        = 0;
                end
            end
        end
        if (rand_mode) begin
            if (gw >= 0) req_valid[gw] = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (i != gw && !req_valid[i] && $urandom_range(0, 2) == 0) begin
                    dbytes[i]    = 8'($urandom);
                    req_valid[i] = 1'b1;
                    wait_cnt[i]  = 0;
                end
            end
        end
    end

    task automatic wait_grant(int max);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (req_ready === 4'b0000 && n < max);
        chk("grant_seen", req_ready !== 4'b0000, 1);
    endtask

    task automatic wait_idle(int max);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(active === 1'b0 && busy === 1'b0) && n < max);
        chk("idle_reached", {active, busy}, 2'b00);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 reset = 1'b1;
        tb_last = 3;
        @(negedge clk);
        #1 reset = 1'b0;
    endtask

    int n;
    int tx_cnt;
    int to_base;
    int g_base;
    logic prev_tx;

    initial begin
        reset      = 1'b1;
        req_valid  = 4'b0000;
        dbytes     = '0;
        force_busy = 1'b0;
        uart_busy  = 1'b0;
        uart_en    = 1'b1;
        rand_mode  = 1'b0;
        dly_cfg    = 2;
        len_cfg    = 20;
        for (int i = 0; i < 4; i++) wait_cnt[i] = 0;

        repeat (2) @(negedge clk);
        chk("rst_transmit", transmit, 0);
        chk("rst_ready", req_ready, 4'b0000);
        chk("rst_timeout", timeout_err, 0);
        chk("rst_active", active, 0);
        chk("rst_txdata", TX_Data, 8'h00);
        chk("rst_grant_id", grant_id, 0);
        #1 reset = 1'b0;

        // single requester, busy 2 cycles after transmit, held 20
        dbytes[0] = 8'hA5;
        req_valid = 4'b0001;
        exp_q.push_back(0);
        wait_grant(20);
        chk("a5_data", TX_Data, 8'hA5);
        chk("a5_ready", req_ready, 4'b0001);
        chk("a5_id", grant_id, 0);
        #1 req_valid = 4'b0000;
        prev_tx = 1'b1;
        n = 0;
        while (busy !== 1'b1 && n < 20) begin
            prev_tx = transmit;
            @(negedge clk);
            n++;
        end
        chk("tx_before_busy", prev_tx, 1);
        chk("tx_after_busy", transmit, 0);
        chk("data_stable", TX_Data, 8'hA5);
        chk("active_wait_done", active, 1);
        wait_idle(40);

        // all valid: order 0,1,2,3,0
        do_reset();
        dly_cfg = 1;
        len_cfg = 4;
        dbytes = {8'h44, 8'h33, 8'h22, 8'h11};
        req_valid = 4'b1111;
        exp_q.push_back(0);
        exp_q.push_back(1);
        exp_q.push_back(2);
        exp_q.push_back(3);
        exp_q.push_back(0);
        repeat (5) wait_grant(60);
        #1 req_valid = 4'b0000;
        chk("rr_order_consumed", exp_q.size(), 0);
        wait_idle(40);

        // busy never rises: timeout after 16 transmit cycles
        uart_en   = 1'b0;
        to_base   = to_cnt;
        req_valid = 4'b0001;
        exp_q.push_back(0);
        wait_grant(20);
        #1 req_valid = 4'b0000;
        tx_cnt = 1;
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (transmit !== 1'b1) break;
            tx_cnt++;
        end
        chk("tx_high_cycles", tx_cnt, 16);
        chk("timeout_pulse", timeout_err, 1);
        chk("timeout_idle", active, 0);
        @(negedge clk);
        chk("timeout_once", to_cnt - to_base, 1);
        chk("timeout_clear", timeout_err, 0);
        #1 uart_en = 1'b1;
        dly_cfg   = 2;
        len_cfg   = 6;
        req_valid = 4'b1111;
        exp_q.push_back(1);
        wait_grant(20);
        #1 req_valid = 4'b0000;
        wait_idle(40);

        // external busy blocks grants in IDLE
        force_busy = 1'b1;
        req_valid  = 4'b0010;
        repeat (8) begin
            @(negedge clk);
            chk("busy_no_ready", req_ready, 4'b0000);
            chk("busy_no_tx", transmit, 0);
        end
        #1 force_busy = 1'b0;
        exp_q.push_back(1);
        wait_grant(10);
        chk("busy_release_id", grant_id, 1);
        #1 req_valid = 4'b0000;
        wait_idle(40);

        // reset in WAIT_DONE
        len_cfg   = 20;
        req_valid = 4'b0100;
        exp_q.push_back(2);
        wait_grant(10);
        #1 req_valid = 4'b0000;
        n = 0;
        while (!(busy === 1'b1 && transmit === 1'b0) && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("in_wait_done", {active, busy, transmit}, 3'b110);
        #1 reset = 1'b1;
        tb_last = 3;
        @(negedge clk);
        chk("midrst_transmit", transmit, 0);
        chk("midrst_active", active, 0);
        chk("midrst_grant_id", grant_id, 0);
        chk("midrst_ready", req_ready, 4'b0000);
        chk("midrst_timeout", timeout_err, 0);
        #1 reset = 1'b0;
        req_valid = 4'b1001;
        exp_q.push_back(0);
        wait_grant(60);
        #1 req_valid = 4'b0000;
        wait_idle(60);

        // randomized traffic, 100 frames
        g_base = grant_cnt;
        rand_mode = 1'b1;
        n = 0;
        while (grant_cnt < g_base + 100 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("random_frames", grant_cnt >= g_base + 100, 1);
        #1 rand_mode = 1'b0;
        @(negedge clk);
        #1 req_valid = 4'b0000;
        wait_idle(100);
        chk("loopback_drained", exp_byte_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
